// File: rtl/sea_byte_loader_pkg.sv
// Shared types and defaults for the SEA byte-serial loader.
package sea_byte_loader_pkg;

  localparam int unsigned HALF_W_DEF = 48;

  typedef enum logic [2:0] {
    ST_LD_K  = 3'd0,
    ST_LD_L  = 3'd1,
    ST_LD_R  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_TX_L  = 3'd5,
    ST_TX_R  = 3'd6
  } state_t;

  function automatic logic is_load(input state_t s);
    return (s == ST_LD_K) || (s == ST_LD_L) || (s == ST_LD_R);
  endfunction

  function automatic logic is_tx(input state_t s);
    return (s == ST_TX_L) || (s == ST_TX_R);
  endfunction

endpackage

// File: rtl/sea_byte_shreg.sv
// W-bit left-shift register: parallel load wins over byte shift-in at the bottom.
module sea_byte_shreg #(
  parameter int unsigned W = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift,
  input  logic [7:0]   sin,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {q[W-9:0], sin};
    end
  end

endmodule

// File: rtl/sea_byte_loader.sv
// Byte-serial front end for the SEA core: loads key/left/right from a byte stream,
// issues them over valid/ready, and streams the captured result back out.
module sea_byte_loader
  import sea_byte_loader_pkg::*;
#(
  parameter int unsigned HALF_W = HALF_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [HALF_W-1:0] core_ki,
  output logic [HALF_W-1:0] core_li,
  output logic [HALF_W-1:0] core_ri,
  output logic              core_valid,
  input  logic              core_ready,
  input  logic              res_valid,
  input  logic [HALF_W-1:0] res_li,
  input  logic [HALF_W-1:0] res_ri,
  output logic [7:0]        dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy
);

  localparam int unsigned NB    = HALF_W / 8;
  localparam int unsigned CNT_W = $clog2(NB);
  localparam int unsigned OUT_W = 2 * HALF_W;

  state_t           state;
  logic [CNT_W-1:0] byte_cnt;
  logic [OUT_W-1:0] out_q;
  logic             last_byte;
  logic             in_xfer;
  logic             out_xfer;
  logic             res_load;

  // Handshake flags are pure decodes of the registered state.
  assign din_ready  = !rst && is_load(state);
  assign core_valid = (state == ST_ISSUE);
  assign dout_valid = is_tx(state);
  assign busy       = !((state == ST_LD_K) && (byte_cnt == '0));
  assign dout       = out_q[OUT_W-1 -: 8];

  assign last_byte = (byte_cnt == CNT_W'(NB - 1));
  assign in_xfer   = din_valid && din_ready;
  assign out_xfer  = dout_valid && dout_ready;
  assign res_load  = (state == ST_WAIT) && res_valid;

  sea_byte_shreg #(.W(HALF_W)) u_ki (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b0),
    .load_val ('0),
    .shift    (in_xfer && (state == ST_LD_K)),
    .sin      (din),
    .q        (core_ki)
  );

  sea_byte_shreg #(.W(HALF_W)) u_li (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b0),
    .load_val ('0),
    .shift    (in_xfer && (state == ST_LD_L)),
    .sin      (din),
    .q        (core_li)
  );

  sea_byte_shreg #(.W(HALF_W)) u_ri (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b0),
    .load_val ('0),
    .shift    (in_xfer && (state == ST_LD_R)),
    .sin      (din),
    .q        (core_ri)
  );

  // Result register: zero fill behind the shifted-out bytes leaves it cleared after TX.
  sea_byte_shreg #(.W(OUT_W)) u_out (
    .clk      (clk),
    .rst      (rst),
    .load     (res_load),
    .load_val ({res_li, res_ri}),
    .shift    (out_xfer),
    .sin      (8'h00),
    .q        (out_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_LD_K;
      byte_cnt <= '0;
    end else begin
      case (state)
        ST_LD_K, ST_LD_L, ST_LD_R: begin
          if (in_xfer) begin
            if (last_byte) begin
              byte_cnt <= '0;
              state    <= (state == ST_LD_K) ? ST_LD_L :
                          (state == ST_LD_L) ? ST_LD_R : ST_ISSUE;
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end
        end
        ST_ISSUE: begin
          if (core_ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (res_valid) state <= ST_TX_L;
        end
        ST_TX_L, ST_TX_R: begin
          if (out_xfer) begin
            if (last_byte) begin
              byte_cnt <= '0;
              state    <= (state == ST_TX_L) ? ST_TX_R : ST_LD_K;
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state    <= ST_LD_K;
          byte_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sea_byte_loader.sv
// Self-checking bench for sea_byte_loader: transaction-level model plus directed literal checks.
module tb_sea_byte_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic [47:0] core_ki, core_li, core_ri;
  logic        core_valid;
  logic        core_ready;
  logic        res_valid;
  logic [47:0] res_li, res_ri;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sea_byte_loader dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .core_ki    (core_ki),
    .core_li    (core_li),
    .core_ri    (core_ri),
    .core_valid (core_valid),
    .core_ready (core_ready),
    .res_valid  (res_valid),
    .res_li     (res_li),
    .res_ri     (res_ri),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy)
  );

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Transaction model: bytes taken in this frame, issue done, result held, bytes sent.
  int          nin = 0;
  bit          issued = 1'b0;
  bit          have_res = 1'b0;
  int          nout = 0;
  logic [7:0]  fb [18];
  logic [95:0] mres = '0;

  function automatic logic [47:0] field(input int base);
    logic [47:0] v = '0;
    for (int i = 0; i < 6; i++) v = {v[39:0], fb[base + i]};
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      nin = 0; issued = 1'b0; have_res = 1'b0; nout = 0; mres = '0;
      for (int i = 0; i < 18; i++) fb[i] = 8'h00;
    end else if (nin < 18) begin
      if (din_valid) begin
        fb[nin] = din;
        nin++;
      end
    end else if (!issued) begin
      if (core_ready) issued = 1'b1;
    end else if (!have_res) begin
      if (res_valid) begin
        have_res = 1'b1;
        mres = {res_li, res_ri};
        nout = 0;
      end
    end else if (dout_ready) begin
      nout++;
      if (nout == 12) begin
        nin = 0; issued = 1'b0; have_res = 1'b0; nout = 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("din_ready", {95'd0, din_ready}, {95'd0, (!rst && nin < 18)});
    chk("core_valid", {95'd0, core_valid}, {95'd0, (nin == 18 && !issued)});
    chk("dout_valid", {95'd0, dout_valid}, {95'd0, have_res});
    chk("dout", {88'd0, dout}, {88'd0, (have_res ? mres[95 - 8*nout -: 8] : 8'h00)});
    chk("busy", {95'd0, busy}, {95'd0, (nin != 0)});
    if (nin == 0 || nin == 18) begin
      chk("core_ki", {48'd0, core_ki}, {48'd0, field(0)});
      chk("core_li", {48'd0, core_li}, {48'd0, field(6)});
      chk("core_ri", {48'd0, core_ri}, {48'd0, field(12)});
    end
  end

  logic [7:0] got_q [$];
  int first_c, last_c;

  // Tasks are entered and left 2 time units after a rising edge.
  task automatic send(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      din = first + 8'(i);
      din_valid = 1'b1;
      @(posedge clk); #2;
    end
    din_valid = 1'b0;
  endtask

  task automatic do_issue();
    bit hs = 1'b0;
    core_ready = 1'b1;
    for (int c = 0; c < 20 && !hs; c++) begin
      @(negedge clk);
      hs = core_valid;
      @(posedge clk); #2;
    end
    core_ready = 1'b0;
    chk("issue_handshake", {95'd0, hs}, 96'd1);
  endtask

  task automatic do_result(input logic [47:0] li, input logic [47:0] ri);
    @(posedge clk); #2;
    res_li = li; res_ri = ri; res_valid = 1'b1;
    @(posedge clk); #2;
    res_valid = 1'b0;
  endtask

  task automatic collect(input bit toggle);
    got_q.delete();
    first_c = -1; last_c = -1;
    for (int c = 0; c < 80 && got_q.size() < 12; c++) begin
      dout_ready = toggle ? (c % 2 == 0) : 1'b1;
      @(negedge clk);
      if (dout_valid && dout_ready) begin
        got_q.push_back(dout);
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      @(posedge clk); #2;
    end
    dout_ready = 1'b1;
    chk("tx_byte_count", 96'(got_q.size()), 96'd12);
  endtask

  task automatic chk_bytes(input string nm, input logic [95:0] exp);
    logic [95:0] act = '0;
    for (int i = 0; i < got_q.size() && i < 12; i++) act[95 - 8*i -: 8] = got_q[i];
    chk(nm, act, exp);
  endtask

  initial begin
    rst = 1'b0; din = 8'h00; din_valid = 1'b0; core_ready = 1'b0;
    res_valid = 1'b0; res_li = '0; res_ri = '0; dout_ready = 1'b1;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", {95'd0, busy}, 96'd0);
    chk("reset_ki", {48'd0, core_ki}, 96'd0);
    chk("reset_din_ready", {95'd0, din_ready}, 96'd1);
    @(posedge clk); #2;

    // Frame 1: plain stream, held issue, result out with no backpressure.
    send(8'h00, 18);
    @(negedge clk);
    chk("f1_core_valid_rise", {95'd0, core_valid}, 96'd1);
    chk("f1_ki", {48'd0, core_ki}, {48'd0, 48'h000102030405});
    chk("f1_li", {48'd0, core_li}, {48'd0, 48'h060708090A0B});
    chk("f1_ri", {48'd0, core_ri}, {48'd0, 48'h0C0D0E0F1011});
    @(posedge clk); #2;
    for (int k = 0; k < 5; k++) begin
      res_li = 48'hFFFF00001111; res_ri = 48'h2222FFFF3333;
      res_valid = (k == 1);
      @(negedge clk);
      chk("hold_core_valid", {95'd0, core_valid}, 96'd1);
      chk("hold_din_ready", {95'd0, din_ready}, 96'd0);
      chk("hold_ri", {48'd0, core_ri}, {48'd0, 48'h0C0D0E0F1011});
      @(posedge clk); #2;
    end
    res_valid = 1'b0;
    do_issue();
    do_result(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6);
    collect(1'b0);
    chk_bytes("f1_dout_seq", 96'hA1A2A3A4A5A6_B1B2B3B4B5B6);
    chk("f1_consecutive", 96'(last_c - first_c), 96'd11);
    @(negedge clk);
    chk("f1_din_ready_after", {95'd0, din_ready}, 96'd1);
    @(posedge clk); #2;

    // Frame 2: stray res_valid during LD_L, core_ready high on ISSUE entry, toggled dout_ready.
    send(8'h30, 8);
    res_li = 48'hEEEEEEEEEEEE; res_ri = 48'hDDDDDDDDDDDD; res_valid = 1'b1;
    @(posedge clk); #2;
    res_valid = 1'b0;
    @(negedge clk);
    chk("ldl_no_tx", {95'd0, dout_valid}, 96'd0);
    @(posedge clk); #2;
    core_ready = 1'b1;
    send(8'h38, 10);
    chk("f2_ki", {48'd0, core_ki}, {48'd0, 48'h303132333435});
    chk("f2_li", {48'd0, core_li}, {48'd0, 48'h363738393A3B});
    chk("f2_ri", {48'd0, core_ri}, {48'd0, 48'h3C3D3E3F4041});
    do_issue();
    @(negedge clk);
    chk("f2_core_valid_drop", {95'd0, core_valid}, 96'd0);
    @(posedge clk); #2;
    do_result(48'hC0C1C2C3C4C5, 48'hD0D1D2D3D4D5);
    collect(1'b1);
    chk_bytes("f2_dout_seq", 96'hC0C1C2C3C4C5_D0D1D2D3D4D5);

    // Reset after 9 bytes, then a fresh frame.
    send(8'h70, 9);
    rst = 1'b1;
    #1;
    chk("mid_rst_din_ready", {95'd0, din_ready}, 96'd0);
    chk("mid_rst_busy", {95'd0, busy}, 96'd0);
    chk("mid_rst_ki", {48'd0, core_ki}, 96'd0);
    chk("mid_rst_li", {48'd0, core_li}, 96'd0);
    chk("mid_rst_ri", {48'd0, core_ri}, 96'd0);
    chk("mid_rst_dout", {88'd0, dout}, 96'd0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    send(8'h50, 18);
    chk("f3_ki", {48'd0, core_ki}, {48'd0, 48'h505152535455});
    chk("f3_li", {48'd0, core_li}, {48'd0, 48'h565758595A5B});
    chk("f3_ri", {48'd0, core_ri}, {48'd0, 48'h5C5D5E5F6061});
    do_issue();
    do_result(48'h123456789ABC, 48'hDEF012345678);
    collect(1'b0);
    chk_bytes("f3_dout_seq", 96'h123456789ABC_DEF012345678);
    repeat (2) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
